// File: rtl/trace_event_pkg.sv
// trace_event_pkg: shared constants and event record for the nop trace event unit.
// OPTIMSOC_TRACE_EVENT_TIMESTAMP_EN adds a 32-bit timestamp field to each event.
package trace_event_pkg;
    localparam logic [7:0]  OPC_NOP           = 8'h15;
    localparam logic [15:0] EVENT_ID_OVERFLOW = 16'hFFFF;

    typedef struct packed {
        logic [15:0] id;
        logic [31:0] value;
`ifdef OPTIMSOC_TRACE_EVENT_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } trace_event_t;
endpackage

// File: rtl/trace_event_fifo.sv
// trace_event_fifo: flop-based synchronous FIFO with simultaneous push/pop, including when full.
// Head data is zeroed while empty so the consumer port reads all-zero after reset.
module trace_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 80
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign o_empty = r_count == '0;
    assign o_full  = r_count == FULL_CNT;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/trace_nop_event_unit.sv
// trace_nop_event_unit: turns l.nop K markers in the exec trace into queued {K, r3, ts} events.
// OPTIMSOC_TRACE_EVENT_TIMESTAMP_EN builds the cycle timestamp; otherwise event_ts_o is 0.
module trace_nop_event_unit
    import trace_event_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trace_valid_i,
    input  logic [31:0] trace_pc_i,
    input  logic [31:0] trace_insn_i,
    input  logic        trace_wben_i,
    input  logic [4:0]  trace_wbreg_i,
    input  logic [31:0] trace_wbdata_i,
    output logic        event_valid_o,
    input  logic        event_ready_i,
    output logic [15:0] event_id_o,
    output logic [31:0] event_value_o,
    output logic [31:0] event_ts_o,
    output logic        drop_pending_o
);
    logic [31:0]  r_r3, r_drop;
    trace_event_t r_cap, w_push_data, w_head;
    logic         r_cap_valid, w_marker, w_full, w_empty, w_ovf, w_push;
    logic [15:0]  w_k;
    logic         w_unused;

    assign w_unused = ^{trace_pc_i, trace_insn_i[23:16]};
    assign w_k      = trace_insn_i[15:0];
    assign w_marker = trace_valid_i && trace_insn_i[31:24] == OPC_NOP
                      && w_k != '0 && w_k != EVENT_ID_OVERFLOW;

`ifdef OPTIMSOC_TRACE_EVENT_TIMESTAMP_EN
    logic [31:0] r_ts;
    always_ff @(posedge clk_i) begin
        r_ts <= rst_i ? '0 : r_ts + 1'b1;
    end
    assign event_ts_o = w_head.ts;
`else
    assign event_ts_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_r3        <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            if (trace_valid_i && trace_wben_i && trace_wbreg_i == 5'd3) r_r3 <= trace_wbdata_i;
            r_cap_valid <= w_marker;
        end
    end

    // r3 is sampled before this cycle's writeback, so a marker sees the prior instruction's write
    always_ff @(posedge clk_i) begin
        if (w_marker) begin
            r_cap.id    <= w_k;
            r_cap.value <= r_r3;
`ifdef OPTIMSOC_TRACE_EVENT_TIMESTAMP_EN
            r_cap.ts    <= r_ts;
`endif
        end
    end

    assign w_ovf  = r_drop != '0 && !w_full;
    assign w_push = w_ovf || (r_cap_valid && !w_full);

    always_comb begin
        w_push_data = r_cap;
        if (w_ovf) begin
            w_push_data.id    = EVENT_ID_OVERFLOW;
            w_push_data.value = r_drop;
`ifdef OPTIMSOC_TRACE_EVENT_TIMESTAMP_EN
            w_push_data.ts    = r_ts;
`endif
        end
    end

    // a marker losing arbitration to the overflow event is itself counted as the next drop
    always_ff @(posedge clk_i) begin
        if (rst_i) r_drop <= '0;
        else if (w_ovf) r_drop <= {31'd0, r_cap_valid};
        else if (r_cap_valid && w_full && r_drop != '1) r_drop <= r_drop + 1'b1;
    end

    trace_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(trace_event_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (event_ready_i),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign event_valid_o  = !w_empty;
    assign event_id_o     = w_head.id;
    assign event_value_o  = w_head.value;
    assign drop_pending_o = r_drop != '0;
endmodule
